// File: rtl/core_pipe_exec_mdu_issue_if.sv
// Execute-stage to MDU issue/collect bundle: upstream instruction handshake,
// MDU request/result signals and writeback handshake.
// master: the issue controller; slave: the surrounding pipeline/MDU/writeback.
interface core_pipe_exec_mdu_issue_if #(
  parameter int unsigned XLEN = 64
);
  // upstream instruction handshake
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      s_op;
  logic            s_word;
  logic [XLEN-1:0] s_rs1;
  logic [XLEN-1:0] s_rs2;
  logic [4:0]      s_rd_addr;

  // MDU request / result
  logic            mdu_valid;
  logic            mdu_op_word;
  logic            mdu_op_mul;
  logic            mdu_op_mulh;
  logic            mdu_op_mulhu;
  logic            mdu_op_mulhsu;
  logic            mdu_op_div;
  logic            mdu_op_divu;
  logic            mdu_op_rem;
  logic            mdu_op_remu;
  logic [XLEN-1:0] mdu_rs1;
  logic [XLEN-1:0] mdu_rs2;
  logic            mdu_flush;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_rd;

  // writeback handshake
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  modport master (
    input  s_valid, s_op, s_word, s_rs1, s_rs2, s_rd_addr,
    output s_ready,
    output mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu,
           mdu_op_mulhsu, mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu,
           mdu_rs1, mdu_rs2, mdu_flush,
    input  mdu_ready, mdu_rd,
    output wb_valid, wb_rd_addr, wb_data, wb_err,
    input  wb_ready
  );

  modport slave (
    output s_valid, s_op, s_word, s_rs1, s_rs2, s_rd_addr,
    input  s_ready,
    input  mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu,
           mdu_op_mulhsu, mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu,
           mdu_rs1, mdu_rs2, mdu_flush,
    output mdu_ready, mdu_rd,
    input  wb_valid, wb_rd_addr, wb_data, wb_err,
    output wb_ready
  );
endinterface

// File: rtl/core_pipe_exec_mdu_issue.sv
// Execute-stage issue/collect controller for the multiply-divide unit.
// Accepts one M-extension instruction, holds the MDU request stable until the
// MDU reports done, pulses the MDU flush to clear its sticky done state, then
// offers the result to writeback. At most one instruction is in flight.
module core_pipe_exec_mdu_issue #(
  parameter int unsigned XLEN = 64
) (
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         flush,
  core_pipe_exec_mdu_issue_if.master   bus
);

  localparam int unsigned XL = XLEN - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic        word_q, word_d;
  logic [XL:0] rs1_q, rs1_d;
  logic [XL:0] rs2_q, rs2_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [XL:0] result_q, result_d;
  logic        err_q, err_d;

  logic        op_onehot;
  logic        op_illegal;
  logic        accept;
  logic        take;
  logic        busy;

  // Classify the incoming op: must be exactly one-hot, and the high-half
  // multiplies have no word form.
  always_comb begin
    op_onehot  = (bus.s_op != 8'd0) && ((bus.s_op & (bus.s_op - 8'd1)) == 8'd0);
    op_illegal = !op_onehot || (bus.s_word && (|bus.s_op[3:1]));
  end

  // Upstream accept: idle, or retiring a response this cycle; flush blocks it.
  always_comb begin
    accept = 1'b0;
    if (!flush) begin
      accept = (state_q == IDLE) || ((state_q == RESP) && bus.wb_ready);
    end
    take = accept && bus.s_valid;
  end

  // Next-state and register updates.
  // A new instruction can only be taken in IDLE or while RESP retires, so the
  // take path is handled ahead of the per-state transitions.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_addr_d = rd_addr_q;
    result_d  = result_q;
    err_d     = err_q;

    if (flush) begin
      state_d = IDLE;
    end else if (take) begin
      op_d      = bus.s_op;
      word_d    = bus.s_word;
      rs1_d     = bus.s_rs1;
      rs2_d     = bus.s_rs2;
      rd_addr_d = bus.s_rd_addr;
      if (op_illegal) begin
        err_d    = 1'b1;
        result_d = '0;
        state_d  = RESP;
      end else begin
        err_d    = 1'b0;
        state_d  = BUSY;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        BUSY: begin
          if (bus.mdu_ready) begin
            result_d = bus.mdu_rd;
            state_d  = CLEAR;
          end
        end
        CLEAR: begin
          state_d = RESP;
        end
        RESP: begin
          if (bus.wb_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q   <= IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_addr_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_addr_q <= rd_addr_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  // Output decode: MDU request only while BUSY, writeback only while RESP.
  always_comb begin
    busy              = (state_q == BUSY);

    bus.s_ready       = accept;

    bus.mdu_valid     = busy;
    bus.mdu_op_word   = busy & word_q;
    bus.mdu_op_mul    = busy & op_q[0];
    bus.mdu_op_mulh   = busy & op_q[1];
    bus.mdu_op_mulhu  = busy & op_q[2];
    bus.mdu_op_mulhsu = busy & op_q[3];
    bus.mdu_op_div    = busy & op_q[4];
    bus.mdu_op_divu   = busy & op_q[5];
    bus.mdu_op_rem    = busy & op_q[6];
    bus.mdu_op_remu   = busy & op_q[7];
    bus.mdu_rs1       = rs1_q;
    bus.mdu_rs2       = rs2_q;
    bus.mdu_flush     = flush | (state_q == CLEAR);

    bus.wb_valid      = (state_q == RESP) && !flush;
    bus.wb_rd_addr    = rd_addr_q;
    bus.wb_data       = result_q;
    bus.wb_err        = err_q;
  end

  // MDU request must not change while the MDU is working on it.
  a_busy_stable: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (state_q == BUSY) |=> ((state_q != BUSY) || $stable({op_q, word_q, rs1_q, rs2_q})));

  // Only legal single ops ever reach the MDU.
  a_busy_onehot: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (state_q == BUSY) |-> $onehot(op_q));

  // A pending writeback holds its payload until accepted or flushed.
  a_resp_hold: assert property (@(posedge g_clk) disable iff (!g_resetn)
    ((state_q == RESP) && !bus.wb_ready && !flush) |=>
      ((state_q == RESP) && $stable({result_q, err_q, rd_addr_q})));

endmodule

// File: doc/core_pipe_exec_mdu_issue.md
# core_pipe_exec_mdu_issue

Execute-stage issue/collect controller for the multiply-divide unit. It accepts one decoded M-extension instruction from the execute pipeline and drives the MDU's valid/op/operand inputs, holding them stable until the MDU raises `ready`. It then captures the result, pulses the MDU flush to clear its sticky done state, and presents the result to writeback through a valid/ready handshake. It is the initiating end of the MDU interface.

## Interface
Parameters:
- XLEN, 64, datapath width; XL = XLEN-1.

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_resetn  in  1  reset; synchronous, active-low.
- flush  in  1  pipeline flush; abandons any operation.
- s_valid  in  1  upstream instruction valid.
- s_ready  out  1  upstream accept.
- s_op  in  8  one-hot op, bit order: [0] mul, [1] mulh, [2] mulhu, [3] mulhsu, [4] div, [5] divu, [6] rem, [7] remu.
- s_word  in  1  32-bit word-form operation.
- s_rs1, s_rs2  in  XLEN  operands.
- s_rd_addr  in  5  destination register.
- mdu_valid  out  1  MDU operation request.
- mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu, mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu  out  1 each  MDU op selects.
- mdu_rs1, mdu_rs2  out  XLEN  MDU operands.
- mdu_flush  out  1  MDU flush/clear.
- mdu_ready  in  1  MDU result valid.
- mdu_rd  in  XLEN  MDU result.
- wb_valid  out  1  result valid to writeback.
- wb_ready  in  1  writeback accept.
- wb_rd_addr  out  5  destination register.
- wb_data  out  XLEN  result.
- wb_err  out  1  illegal op; `wb_data` is 0.

## Operation
- FSM states: IDLE, BUSY, CLEAR, RESP. Reset and flush both force IDLE.
- Registered after reset: op/word/rs1/rs2/rd_addr registers are 0; result is 0; err is 0.
- Illegal op:
  - Applies when `s_op` is not exactly one-hot, including all-zero.
  - Also applies when `s_word` is set with mulh, mulhu or mulhsu.
- IDLE:
  - `s_ready` = 1.
  - On `s_valid`: latch op, word, rs1, rs2 and rd_addr.
  - Legal op goes to BUSY.
  - Illegal op sets err, sets result to 0 and goes to RESP. The MDU is not touched.
- BUSY:
  - `mdu_valid` = 1.
  - MDU op selects, `mdu_op_word`, `mdu_rs1` and `mdu_rs2` are driven from the latched registers and stay constant for the whole state. The MDU samples operand signs combinationally at its output.
  - On `mdu_ready` = 1: capture `mdu_rd` into the result register and go to CLEAR.
- CLEAR:
  - `mdu_valid` = 0.
  - `mdu_flush` = 1 for exactly this one cycle, which clears the MDU's sticky done/run state.
  - Next state is RESP.
- RESP:
  - `wb_valid` = 1; `wb_data`, `wb_rd_addr` and `wb_err` come from registers.
  - On `wb_ready` = 1: go to IDLE.
  - Back-to-back: `s_ready` is also 1 in RESP when `wb_ready` = 1. If `s_valid` is also 1, the new instruction is latched and the next state is BUSY, or RESP if illegal.
- MDU op selects are 0 in every state except BUSY.
- `mdu_flush` = `flush` | (state == CLEAR), combinational.
- Flush in any state:
  - Next state is IDLE; the result is discarded.
  - `s_ready` and `wb_valid` are forced to 0 in the flush cycle.
  - A flush in BUSY clears the MDU through the passthrough; CLEAR is not visited.
- Reset mid-operation behaves as flush, except `mdu_flush` is not required during reset. The MDU shares `g_resetn`.
- No width conversion: word-form sign extension is done inside the MDU. The result is forwarded unmodified.

## Timing
- Outputs during and after reset: `s_ready` = 1 (IDLE); `mdu_valid`, all MDU op selects, `wb_valid` and `wb_err` = 0; `wb_data` = 0.
- Handshake cycle T (`s_valid` & `s_ready`) → `mdu_valid` high from T+1.
- `mdu_ready` sampled high in cycle C → `mdu_flush` in C+1 → `wb_valid` from C+2.
- Controller overhead: 1 cycle before issue, 2 cycles after MDU completion.
- Illegal op accepted at T → `wb_valid` at T+1.
- `wb_valid` and its data hold until `wb_ready`; no drop without flush.
- At most one instruction is in flight.

## Test plan
- MUL, rs1=3, rs2=5 → `mdu_valid` from T+1 with `mdu_op_mul`=1; `wb_data`=15 two cycles after `mdu_ready`; `mdu_flush` one-cycle pulse.
- DIV, rs1=-7, rs2=2 → `wb_data`=0xFFFF_FFFF_FFFF_FFFD. MULW, rs1=rs2=0x10000 → `wb_data`=0.
- Flush 3 cycles into BUSY → `mdu_flush`=1 that cycle, IDLE next, no `wb_valid`. Follow with MULHU, rs1=rs2=2^63 → `wb_data`=2^62.
- Back-to-back: `wb_ready` and `s_valid` both high in RESP → second op accepted with no idle cycle. `wb_ready` held low 5 cycles → `wb_data` stable.
- `s_op`=0x03, `s_op`=0, and mulh with `s_word`=1 → each gives `wb_err`=1, `wb_data`=0 at T+1, `mdu_valid` never high.
- Reset asserted in BUSY → IDLE, `s_ready`=1, all registered outputs 0 next cycle.
